// File: rtl/alien_calc_seq.sv
// Sequential alien calculator: start/busy/done handshake around add/sub/shift-add mul/restoring div,
// with an 8-digit multiplexed seven-segment scanner showing the latched operands and the result.
module alien_calc_seq #(
  parameter int unsigned W           = 5,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           i_start,
  input  logic [1:0]     i_Calc,
  input  logic [W-1:0]   i_A,
  input  logic [W-1:0]   i_B,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_Result,
  output logic           o_Neg,
  output logic           o_Err,
  output logic [7:0]     o_enable,
  output logic [6:0]     o_CAG,
  output logic           o_DP
);

  localparam int unsigned RW = 2 * W;
  localparam int unsigned NW = $clog2(W);
  localparam int unsigned CW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {IDLE, EXEC, FIN} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [1:0]      op_q, op_d;
  logic [NW-1:0]   n_q, n_d;
  logic [RW-1:0]   acc_q, acc_d, mc_q, mc_d;
  logic [W-1:0]    mp_q, mp_d, rem_q, rem_d, quot_q, quot_d;
  logic [RW-1:0]   result_q, result_d;
  logic            neg_q, neg_d, err_q, err_d, busy_q, done_q;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      en_q;
  logic [6:0]      cag_q;
  logic            dp_q;

  // One iteration of each multi-cycle datapath
  logic [RW-1:0]   acc_n;
  logic [W:0]      div_sh, div_tr;
  logic            div_ok;
  logic [W-1:0]    rem_n, quot_n, diff_ab, diff_ba;
  logic            last;

  assign acc_n   = mp_q[0] ? acc_q + mc_q : acc_q;
  assign div_sh  = {rem_q, quot_q[W-1]};
  assign div_tr  = div_sh - {1'b0, b_q};
  assign div_ok  = ~div_tr[W];
  assign rem_n   = div_ok ? div_tr[W-1:0] : div_sh[W-1:0];
  assign quot_n  = {quot_q[W-2:0], div_ok};
  assign diff_ab = a_q - b_q;
  assign diff_ba = b_q - a_q;
  assign last    = (n_q == NW'(W - 1));

  // Control FSM and operation datapath
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    n_d      = n_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    mp_d     = mp_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    result_d = result_q;
    neg_d    = neg_q;
    err_d    = err_q;
    case (state_q)
      IDLE, FIN: begin
        if (state_q == FIN) state_d = IDLE;
        if (i_start) begin
          state_d = EXEC;
          a_d     = i_A;
          b_d     = i_B;
          op_d    = i_Calc;
          n_d     = '0;
          acc_d   = '0;
          mc_d    = RW'(i_A);
          mp_d    = i_B;
          rem_d   = '0;
          quot_d  = i_A;
        end
      end
      EXEC: begin
        n_d = n_q + NW'(1);
        case (op_q)
          2'b00: begin
            result_d = RW'(a_q) + RW'(b_q);
            neg_d    = 1'b0;
            err_d    = 1'b0;
            state_d  = FIN;
          end
          2'b01: begin
            result_d = (a_q < b_q) ? RW'(diff_ba) : RW'(diff_ab);
            neg_d    = (a_q < b_q);
            err_d    = 1'b0;
            state_d  = FIN;
          end
          2'b10: begin
            acc_d = acc_n;
            mc_d  = mc_q << 1;
            mp_d  = mp_q >> 1;
            if (last) begin
              result_d = acc_n;
              neg_d    = 1'b0;
              err_d    = 1'b0;
              state_d  = FIN;
            end
          end
          default: begin
            if (b_q == '0) begin
              result_d = '0;
              neg_d    = 1'b0;
              err_d    = 1'b1;
              state_d  = FIN;
            end else begin
              rem_d  = rem_n;
              quot_d = quot_n;
              if (last) begin
                result_d = {rem_n, quot_n};
                neg_d    = 1'b0;
                err_d    = 1'b0;
                state_d  = FIN;
              end
            end
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // Display scan: digit selection and glyph lookup
  logic [31:0] disp;
  logic [3:0]  nib;
  logic [6:0]  glyph;
  logic        dp_d;

  assign disp = {8'(a_q), 8'(b_q), 16'(result_q)};
  assign nib  = disp[{idx_q, 2'b00} +: 4];
  assign dp_d = ~(((idx_q == 3'd3) && neg_q) || ((idx_q == 3'd0) && err_q));

  always_comb begin
    rcnt_d = rcnt_q + CW'(1);
    idx_d  = idx_q;
    if (rcnt_q == CW'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = idx_q + 3'd1;
    end
    case (nib)
      4'h0: glyph = 7'b0000001;
      4'h1: glyph = 7'b1001111;
      4'h2: glyph = 7'b0010010;
      4'h3: glyph = 7'b0000110;
      4'h4: glyph = 7'b1001100;
      4'h5: glyph = 7'b0100100;
      4'h6: glyph = 7'b0100000;
      4'h7: glyph = 7'b0001111;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0000100;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b1100000;
      4'hC: glyph = 7'b0110001;
      4'hD: glyph = 7'b1000010;
      4'hE: glyph = 7'b0110000;
      default: glyph = 7'b0111000;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      mp_q     <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rcnt_q   <= '0;
      idx_q    <= '0;
      en_q     <= 8'hFE;
      cag_q    <= 7'b0000001;
      dp_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      mp_q     <= mp_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      busy_q   <= (state_d == EXEC);
      done_q   <= (state_d == FIN);
      rcnt_q   <= rcnt_d;
      idx_q    <= idx_d;
      en_q     <= ~(8'b1 << idx_q);
      cag_q    <= glyph;
      dp_q     <= dp_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_Result = result_q;
  assign o_Neg    = neg_q;
  assign o_Err    = err_q;
  assign o_enable = en_q;
  assign o_CAG    = cag_q;
  assign o_DP     = dp_q;

endmodule
